// File: rtl/wt_mem_arbiter.sv
// Arbitrates I$ and D$ requests onto one memory adapter channel through a one-entry slot,
// tracking per-source outstanding credits and routing return strobes to the owning cache.
module wt_mem_arbiter #(
  parameter int IReqWidth      = 64,
  parameter int DReqWidth      = 128,
  parameter int PayloadWidth   = 128,
  parameter int MaxOutstanding = 4,
  parameter int StarveLimit    = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    icache_req_i,
  input  logic [IReqWidth-1:0]    icache_data_i,
  output logic                    icache_ack_o,
  input  logic                    dcache_req_i,
  input  logic [DReqWidth-1:0]    dcache_data_i,
  output logic                    dcache_ack_o,
  output logic                    mem_valid_o,
  input  logic                    mem_ready_i,
  output logic                    mem_src_o,
  output logic [PayloadWidth-1:0] mem_data_o,
  input  logic                    rtrn_valid_i,
  input  logic                    rtrn_src_i,
  input  logic                    rtrn_last_i,
  output logic                    icache_rtrn_vld_o,
  output logic                    dcache_rtrn_vld_o,
  input  logic                    drain_i,
  output logic                    drained_o,
  output logic [3:0]              i_outstanding_o,
  output logic [3:0]              d_outstanding_o,
  output logic                    err_o
);

  localparam logic [3:0] MAX_OUT    = 4'(MaxOutstanding);
  localparam logic [3:0] STARVE_MAX = 4'(StarveLimit);

  typedef enum logic {EMPTY, FULL} slot_e;

  slot_e                   state, state_next;
  logic [PayloadWidth-1:0] slot_data;
  logic                    slot_src;
  logic [3:0]              i_cnt, d_cnt, starve, starve_next;
  logic                    err;
  logic                    can_grant, i_elig, d_elig, i_win, d_win, grant;
  logic                    i_dec, d_dec;

  function automatic logic [PayloadWidth-1:0] zext_i(input logic [IReqWidth-1:0] d);
    logic [PayloadWidth-1:0] r;
    r = '0;
    r[IReqWidth-1:0] = d;
    return r;
  endfunction

  function automatic logic [PayloadWidth-1:0] zext_d(input logic [DReqWidth-1:0] d);
    logic [PayloadWidth-1:0] r;
    r = '0;
    r[DReqWidth-1:0] = d;
    return r;
  endfunction

  // A decrement at zero is an underflow: it is dropped (and flagged separately).
  function automatic logic [3:0] credit_next(input logic [3:0] cnt, input logic inc,
                                             input logic dec);
    logic dec_ok;
    dec_ok = dec && (cnt != 4'd0);
    case ({inc, dec_ok})
      2'b10:   return cnt + 4'd1;
      2'b01:   return cnt - 4'd1;
      default: return cnt;
    endcase
  endfunction

  // Grant stage: reset gating keeps acks silent while rst_ni is low.
  assign can_grant = rst_ni && !drain_i && ((state == EMPTY) || mem_ready_i);
  assign i_elig    = icache_req_i && (i_cnt < MAX_OUT) && can_grant;
  assign d_elig    = dcache_req_i && (d_cnt < MAX_OUT) && can_grant;
  assign i_win     = i_elig && (!d_elig || (starve == STARVE_MAX));
  assign d_win     = d_elig && !i_win;
  assign grant     = i_win || d_win;

  assign i_dec = rtrn_valid_i && rtrn_last_i && !rtrn_src_i;
  assign d_dec = rtrn_valid_i && rtrn_last_i && rtrn_src_i;

  always_comb begin
    state_next = state;
    if (grant)
      state_next = FULL;
    else if ((state == FULL) && mem_ready_i)
      state_next = EMPTY;
  end

  always_comb begin
    starve_next = starve;
    if (i_win || !icache_req_i)
      starve_next = 4'd0;
    else if (d_win && i_elig && (starve != STARVE_MAX))
      starve_next = starve + 4'd1;
  end

  // Slot / credit register stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= EMPTY;
      slot_data <= '0;
      slot_src  <= 1'b0;
      i_cnt     <= 4'd0;
      d_cnt     <= 4'd0;
      starve    <= 4'd0;
      err       <= 1'b0;
    end else begin
      state  <= state_next;
      if (grant) begin
        slot_src  <= d_win;
        slot_data <= d_win ? zext_d(dcache_data_i) : zext_i(icache_data_i);
      end
      i_cnt  <= credit_next(i_cnt, i_win, i_dec);
      d_cnt  <= credit_next(d_cnt, d_win, d_dec);
      starve <= starve_next;
      err    <= err || (i_dec && (i_cnt == 4'd0)) || (d_dec && (d_cnt == 4'd0));
    end
  end

  assign icache_ack_o      = i_win;
  assign dcache_ack_o      = d_win;
  assign mem_valid_o       = (state == FULL);
  assign mem_src_o         = slot_src;
  assign mem_data_o        = slot_data;
  assign icache_rtrn_vld_o = rtrn_valid_i && !rtrn_src_i;
  assign dcache_rtrn_vld_o = rtrn_valid_i && rtrn_src_i;
  assign drained_o         = drain_i && (state == EMPTY) && (i_cnt == 4'd0) && (d_cnt == 4'd0);
  assign i_outstanding_o   = i_cnt;
  assign d_outstanding_o   = d_cnt;
  assign err_o             = err;

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// Self-checking bench for wt_mem_arbiter: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_wt_mem_arbiter;

  localparam int MAXO = 4;
  localparam int SLIM = 3;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         icache_req, icache_ack, dcache_req, dcache_ack;
  logic [63:0]  icache_data;
  logic [127:0] dcache_data;
  logic         mem_valid, mem_ready, mem_src;
  logic [127:0] mem_data;
  logic         rtrn_valid, rtrn_src, rtrn_last, icache_rtrn_vld, dcache_rtrn_vld;
  logic         drain, drained, err;
  logic [3:0]   i_out, d_out;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  wt_mem_arbiter #(
    .IReqWidth(64), .DReqWidth(128), .PayloadWidth(128),
    .MaxOutstanding(MAXO), .StarveLimit(SLIM)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .icache_req_i(icache_req), .icache_data_i(icache_data), .icache_ack_o(icache_ack),
    .dcache_req_i(dcache_req), .dcache_data_i(dcache_data), .dcache_ack_o(dcache_ack),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_src_o(mem_src),
    .mem_data_o(mem_data),
    .rtrn_valid_i(rtrn_valid), .rtrn_src_i(rtrn_src), .rtrn_last_i(rtrn_last),
    .icache_rtrn_vld_o(icache_rtrn_vld), .dcache_rtrn_vld_o(dcache_rtrn_vld),
    .drain_i(drain), .drained_o(drained),
    .i_outstanding_o(i_out), .d_outstanding_o(d_out), .err_o(err)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    icache_req = 0; icache_data = '0; dcache_req = 0; dcache_data = '0;
    mem_ready = 0; rtrn_valid = 0; rtrn_src = 0; rtrn_last = 0; drain = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_ni = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_ni = 1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic drn, rv, rs, rl;
    logic e_ivld, e_dvld, e_drained;
  } vec_t;

  // Reference model state
  typedef struct { logic src; logic [127:0] data; } slot_t;
  slot_t m_q[$];
  int    m_icnt, m_dcnt, m_starve;
  logic  m_err;

  initial begin
    vec_t vt[6];
    int   order[8];
    int   last_src;
    logic [63:0] i0;
    logic [127:0] d0;
    logic i_pend, d_pend;

    rst_ni = 1;
    clear_inputs();
    #2 rst_ni = 0;
    icache_req = 1; dcache_req = 1; mem_ready = 1;
    @(negedge clk);
    chk("rst_iack", icache_ack, 0);
    chk("rst_dack", dcache_ack, 0);
    chk("rst_valid", mem_valid, 0);
    chk("rst_src", mem_src, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_icnt", i_out, 0);
    chk("rst_dcnt", d_out, 0);
    chk("rst_err", err, 0);
    do_reset();

    // Vector table: return routing and idle drain handshake
    vt[0] = '{0,0,0,0, 0,0,0};
    vt[1] = '{0,1,0,0, 1,0,0};
    vt[2] = '{0,1,1,0, 0,1,0};
    vt[3] = '{1,0,0,0, 0,0,1};
    vt[4] = '{1,1,1,0, 0,1,1};
    vt[5] = '{1,1,0,0, 1,0,1};
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      drain = vt[k].drn; rtrn_valid = vt[k].rv; rtrn_src = vt[k].rs; rtrn_last = vt[k].rl;
      @(negedge clk);
      chk($sformatf("vec%0d_ivld", k), icache_rtrn_vld, vt[k].e_ivld);
      chk($sformatf("vec%0d_dvld", k), dcache_rtrn_vld, vt[k].e_dvld);
      chk($sformatf("vec%0d_drained", k), drained, vt[k].e_drained);
    end

    // Single I$ request, zero-extended payload
    do_reset();
    next_cycle();
    icache_req = 1; icache_data = 64'hAB; mem_ready = 1;
    @(negedge clk);
    chk("t1_ack", icache_ack, 1);
    chk("t1_valid0", mem_valid, 0);
    next_cycle();
    icache_req = 0;
    @(negedge clk);
    chk("t1_valid1", mem_valid, 1);
    chk("t1_src", mem_src, 0);
    chk("t1_data", mem_data, 128'hAB);
    chk("t1_noack", icache_ack, 0);
    next_cycle();
    @(negedge clk);
    chk("t1_empty", mem_valid, 0);
    chk("t1_icnt", i_out, 1);

    // Starvation: D,D,D,I,D,D,D,I
    do_reset();
    order = '{1,1,1,0,1,1,1,0};
    last_src = -1;
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      icache_req = 1; dcache_req = 1; mem_ready = 1;
      icache_data = {$urandom, $urandom};
      dcache_data = {$urandom, $urandom, $urandom, $urandom};
      rtrn_valid = (last_src >= 0); rtrn_last = (last_src >= 0); rtrn_src = (last_src == 1);
      @(negedge clk);
      last_src = dcache_ack ? 1 : (icache_ack ? 0 : 2);
      chk($sformatf("starve_grant%0d", k), 128'(last_src), 128'(order[k]));
    end
    next_cycle();
    icache_req = 0; dcache_req = 0;
    rtrn_valid = 1; rtrn_last = 1; rtrn_src = (last_src == 1);
    next_cycle();
    rtrn_valid = 0; rtrn_last = 0;
    @(negedge clk);
    chk("starve_icnt", i_out, 0);
    chk("starve_dcnt", d_out, 0);

    // Credit limit
    do_reset();
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      dcache_req = 1; dcache_data = 128'(k); mem_ready = 1;
      @(negedge clk);
      chk($sformatf("cred_ack%0d", k), dcache_ack, 1);
    end
    next_cycle();
    @(negedge clk);
    chk("cred_held", dcache_ack, 0);
    chk("cred_full", d_out, 4);
    next_cycle();
    rtrn_valid = 1; rtrn_src = 1; rtrn_last = 1;
    @(negedge clk);
    chk("cred_ret_cycle", dcache_ack, 0);
    next_cycle();
    rtrn_valid = 0; rtrn_last = 0;
    @(negedge clk);
    chk("cred_regrant", dcache_ack, 1);
    next_cycle();
    dcache_req = 0;
    @(negedge clk);
    chk("cred_back4", d_out, 4);

    // Backpressure stability, then back-to-back grant
    do_reset();
    d0 = {$urandom, $urandom, $urandom, $urandom};
    i0 = {$urandom, $urandom};
    next_cycle();
    dcache_req = 1; dcache_data = d0; mem_ready = 0;
    @(negedge clk);
    chk("bp_dack", dcache_ack, 1);
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      dcache_req = 0; icache_req = 1; icache_data = i0;
      @(negedge clk);
      chk($sformatf("bp_valid%0d", k), mem_valid, 1);
      chk($sformatf("bp_src%0d", k), mem_src, 1);
      chk($sformatf("bp_data%0d", k), mem_data, d0);
      chk($sformatf("bp_noack%0d", k), icache_ack, 0);
    end
    next_cycle();
    mem_ready = 1;
    @(negedge clk);
    chk("b2b_iack", icache_ack, 1);
    next_cycle();
    icache_req = 0; mem_ready = 0;
    @(negedge clk);
    chk("b2b_valid", mem_valid, 1);
    chk("b2b_src", mem_src, 0);
    chk("b2b_data", mem_data, {64'h0, i0});

    // Drain with slot full and two I$ transactions outstanding
    do_reset();
    next_cycle();
    icache_req = 1; icache_data = 64'h11; mem_ready = 1;
    @(negedge clk);
    chk("dr_ack0", icache_ack, 1);
    next_cycle();
    icache_data = 64'h22;
    @(negedge clk);
    chk("dr_ack1", icache_ack, 1);
    next_cycle();
    icache_req = 0; mem_ready = 0; drain = 1; dcache_req = 1;
    @(negedge clk);
    chk("dr_noack2", dcache_ack, 0);
    chk("dr_drained2", drained, 0);
    chk("dr_icnt2", i_out, 2);
    chk("dr_valid2", mem_valid, 1);
    next_cycle();
    mem_ready = 1;
    @(negedge clk);
    chk("dr_noack3", dcache_ack, 0);
    chk("dr_drained3", drained, 0);
    next_cycle();
    mem_ready = 0; rtrn_valid = 1; rtrn_src = 0; rtrn_last = 1;
    @(negedge clk);
    chk("dr_valid4", mem_valid, 0);
    chk("dr_drained4", drained, 0);
    next_cycle();
    @(negedge clk);
    chk("dr_icnt5", i_out, 1);
    chk("dr_drained5", drained, 0);
    next_cycle();
    rtrn_valid = 0; rtrn_last = 0;
    @(negedge clk);
    chk("dr_drained6", drained, 1);
    chk("dr_noack6", dcache_ack, 0);
    next_cycle();
    dcache_req = 0; drain = 0;
    @(negedge clk);
    chk("dr_release", drained, 0);

    // Return underflow is sticky until reset
    do_reset();
    next_cycle();
    rtrn_valid = 1; rtrn_src = 0; rtrn_last = 1;
    @(negedge clk);
    chk("uf_err_before", err, 0);
    next_cycle();
    rtrn_valid = 0; rtrn_last = 0;
    @(negedge clk);
    chk("uf_icnt", i_out, 0);
    chk("uf_err", err, 1);
    repeat (3) next_cycle();
    @(negedge clk);
    chk("uf_sticky", err, 1);
    do_reset();
    @(negedge clk);
    chk("uf_cleared", err, 0);

    // Reset mid-transaction
    next_cycle();
    dcache_req = 1; mem_ready = 0;
    @(negedge clk);
    chk("mr_dack", dcache_ack, 1);
    next_cycle();
    rst_ni = 0; dcache_req = 0; icache_req = 1;
    @(negedge clk);
    chk("mr_noack", icache_ack, 0);
    chk("mr_valid", mem_valid, 0);
    chk("mr_dcnt", d_out, 0);
    do_reset();

    // Randomized traffic against reference model
    m_q.delete(); m_icnt = 0; m_dcnt = 0; m_starve = 0; m_err = 0;
    i_pend = 0; d_pend = 0;
    for (int c = 0; c < 1500; c++) begin
      logic ev, can, ie, de, iw, dw, idec, ddec;
      next_cycle();
      if (!i_pend && ($urandom % 3 == 0)) begin i_pend = 1; icache_data = {$urandom, $urandom}; end
      if (!d_pend && ($urandom % 3 == 0)) begin
        d_pend = 1; dcache_data = {$urandom, $urandom, $urandom, $urandom};
      end
      icache_req = i_pend; dcache_req = d_pend;
      mem_ready  = ($urandom % 4 != 0);
      drain      = ($urandom % 16 == 0);
      rtrn_valid = ($urandom % 3 == 0);
      rtrn_src   = $urandom % 2;
      rtrn_last  = ($urandom % 2 == 1) && ((rtrn_src ? m_dcnt : m_icnt) > 0);
      @(negedge clk);
      ev  = (m_q.size() != 0);
      can = !drain && (!ev || mem_ready);
      ie  = icache_req && (m_icnt < MAXO) && can;
      de  = dcache_req && (m_dcnt < MAXO) && can;
      iw  = ie && (!de || m_starve == SLIM);
      dw  = de && !iw;
      chk("rnd_iack", icache_ack, iw);
      chk("rnd_dack", dcache_ack, dw);
      chk("rnd_valid", mem_valid, ev);
      if (ev) begin
        chk("rnd_src", mem_src, m_q[0].src);
        chk("rnd_data", mem_data, m_q[0].data);
      end
      chk("rnd_icnt", i_out, 4'(m_icnt));
      chk("rnd_dcnt", d_out, 4'(m_dcnt));
      chk("rnd_err", err, m_err);
      chk("rnd_drained", drained, drain && !ev && m_icnt == 0 && m_dcnt == 0);
      chk("rnd_ivld", icache_rtrn_vld, rtrn_valid && !rtrn_src);
      chk("rnd_dvld", dcache_rtrn_vld, rtrn_valid && rtrn_src);
      // advance model to the next edge
      if (ev && mem_ready) void'(m_q.pop_front());
      if (iw) m_q.push_back('{1'b0, {64'h0, icache_data}});
      if (dw) m_q.push_back('{1'b1, dcache_data});
      idec = rtrn_valid && rtrn_last && !rtrn_src;
      ddec = rtrn_valid && rtrn_last && rtrn_src;
      if (idec) begin if (m_icnt == 0) m_err = 1; else m_icnt--; end
      if (ddec) begin if (m_dcnt == 0) m_err = 1; else m_dcnt--; end
      if (iw) m_icnt++;
      if (dw) m_dcnt++;
      if (iw || !icache_req) m_starve = 0;
      else if (dw && ie && m_starve < SLIM) m_starve++;
      if (iw) i_pend = 0;
      if (dw) d_pend = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/wt_mem_arbiter.md
Name: wt_mem_arbiter

Overview:
- Shares the single memory adapter request channel between the write-through I$ and D$ refill/write paths.
- Arbitrates the two req/ack requesters and holds the winner in a one-entry output slot until the adapter accepts it.
- Tracks outstanding transactions per source with credit limits and routes return-valid strobes back to the owning cache.
- Provides a drain handshake for flush and fence sequencing.

Parameters:
- IReqWidth, 64, width of the packed I$ request payload.
- DReqWidth, 128, width of the packed D$ request payload.
- PayloadWidth, 128, width of mem_data_o; must be ≥ max(IReqWidth, DReqWidth); narrower payloads are zero-extended.
- MaxOutstanding, 4, per-source credit limit, range 1..15.
- StarveLimit, 3, number of consecutive D$ grants allowed while I$ is waiting, range 1..15.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- icache_req_i  in  1  I$ request, held high until acked
- icache_data_i  in  IReqWidth  I$ payload, stable while icache_req_i is high
- icache_ack_o  out  1  one-cycle grant pulse
- dcache_req_i  in  1  D$ request, held high until acked
- dcache_data_i  in  DReqWidth  D$ payload
- dcache_ack_o  out  1  one-cycle grant pulse
- mem_valid_o  out  1  slot holds a request for the adapter
- mem_ready_i  in  1  adapter accepts the slot
- mem_src_o  out  1  source of the slot (0 = I$, 1 = D$)
- mem_data_o  out  PayloadWidth  slot payload
- rtrn_valid_i  in  1  return beat valid
- rtrn_src_i  in  1  return owner (0 = I$, 1 = D$)
- rtrn_last_i  in  1  final beat of a transaction
- icache_rtrn_vld_o  out  1  equals rtrn_valid_i && !rtrn_src_i
- dcache_rtrn_vld_o  out  1  equals rtrn_valid_i && rtrn_src_i
- drain_i  in  1  block new grants
- drained_o  out  1  drain complete
- i_outstanding_o  out  4  I$ credit counter
- d_outstanding_o  out  4  D$ credit counter
- err_o  out  1  sticky return-underflow error

Behaviour:
- Reset values: mem_valid_o=0, mem_src_o=0, mem_data_o=0, both acks=0, both counters=0, err_o=0, starve counter=0.
- Slot FSM has two states, EMPTY and FULL.
  - A grant may issue when the slot is EMPTY, or when it is FULL with mem_ready_i=1 (back-to-back transfer).
  - A grant captures the payload into the slot and pulses the winner's ack in the same cycle.
  - mem_valid_o rises the next cycle, giving 1-cycle request-to-valid latency.
  - FULL→EMPTY occurs on mem_valid_o && mem_ready_i with no concurrent grant.
  - mem_data_o and mem_src_o stay stable while mem_valid_o=1 && !mem_ready_i.
- Eligibility: a source is eligible when its req is high, its counter < MaxOutstanding, drain_i=0, and its ack is not already asserted this cycle. An acked request must deassert or present a new payload the next cycle.
- Priority:
  - D$ wins by default.
  - The I$ wins when only it is eligible, or when starve==StarveLimit and it is eligible.
  - starve increments on each D$ grant while the I$ is eligible but loses.
  - starve clears on an I$ grant or on any cycle the I$ is not requesting.
  - starve saturates at StarveLimit.
- Credits:
  - The counter of the granted source increments at grant.
  - The counter of rtrn_src_i decrements on rtrn_valid_i && rtrn_last_i.
  - A simultaneous increment and decrement on the same source leaves the counter unchanged.
  - Non-last beats do not change the counters.
  - A decrement when the counter is 0 is ignored and sets err_o; err_o clears only on reset.
- Returns: the rtrn valid outputs are combinational and do not depend on grants or drain.
- Drain:
  - drain_i blocks new grants starting in the same cycle; a slot that is already FULL still completes.
  - drained_o = drain_i && slot EMPTY && both counters 0 (combinational).
- Reset asserted mid-transaction discards the slot and counters; no ack is issued while rst_ni=0.

Test Plan:
- Idle, icache_req_i=1 with payload 0xAB → icache_ack_o pulses in cycle 0; cycle 1 shows mem_valid_o=1, mem_src_o=0, mem_data_o=0xAB (zero-extended); with mem_ready_i=1, slot EMPTY in cycle 2, i_outstanding_o=1.
- Both requesting continuously, mem_ready_i=1, StarveLimit=3, returns acking each transaction → grant order D,D,D,I,D,D,D,I.
- D$ issues 4 requests with no returns, MaxOutstanding=4 → 5th held off, dcache_ack_o=0; one rtrn_valid_i/rtrn_src_i=1/rtrn_last_i=1 → grant issues the next cycle, d_outstanding_o returns to 4.
- mem_ready_i=0 for 5 cycles with slot FULL → mem_data_o and mem_src_o stable, no further acks; ready=1 with a pending request → back-to-back grant with no bubble.
- drain_i=1 with slot FULL and i_outstanding_o=2 → no new acks; drained_o=1 only after the slot is accepted and 2 last-beats return.
- rtrn_last_i on src 0 with i_outstanding_o=0 → counter stays 0, err_o=1 until reset.
